tick_period_meter: RTL

- Receive-side companion to prog_timer: measures the clock-cycle interval between rising edges on a tick input, e.g. prog_timer's zero output.
- Reports each measured period with a one-cycle valid strobe.
- Checks the period against an expected value plus a tolerance window.
- Flags a timeout when ticks stop arriving. Used in benches and on-board self-check of timer-driven blocks.

---
 rtl/tick_period_meter.sv | 113 +++++++++++
 1 files changed

// File: rtl/tick_period_meter.sv
// Tick period meter: measures the number of clk cycles between rising edges
// on tick_in, reports each period with a one-cycle valid strobe, checks it
// against expected +/- tolerance, and flags a sticky timeout when ticks stop.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   enable     measurement enable; low forces IDLE
//   tick_in    tick input, synchronous to clk (pulse or level)
//   expected   nominal period in cycles
//   tolerance  allowed absolute deviation from expected, in cycles
//   period     last measured period in cycles
//   valid      one-cycle strobe: period and in_range updated
//   in_range   |period - expected| <= tolerance for the last measurement
//   timeout    sticky: no edge seen within TIMEOUT cycles
//   edge_count rising edges since reset or enable rise (wraps)
module tick_period_meter #(
    parameter int unsigned      WIDTH   = 24,
    parameter logic [WIDTH-1:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] expected,
    input  logic [7:0]       tolerance,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             in_range,
    output logic             timeout,
    output logic [15:0]      edge_count
);

    localparam int unsigned DW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             tick_d;
    logic             tick_edge;
    logic [DW-1:0]    diff;
    logic [DW-1:0]    mag;
    logic             in_window;

    // Rising edge of tick_in; a held-high level yields a single edge.
    assign tick_edge = tick_in & ~tick_d;

    // One extra bit keeps cnt - expected signed without overflow.
    assign diff      = {1'b0, cnt} - {1'b0, expected};
    assign mag       = diff[WIDTH] ? (DW'(0) - diff) : diff;
    assign in_window = (mag <= DW'(tolerance));

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tick_d     <= 1'b0;
            period     <= '0;
            valid      <= 1'b0;
            in_range   <= 1'b0;
            timeout    <= 1'b0;
            edge_count <= '0;
        end else begin
            tick_d <= tick_in;
            valid  <= 1'b0;
            if (!enable) begin
                // Any in-flight measurement is discarded.
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= ARM;
                        cnt        <= '0;
                        edge_count <= '0;
                    end
                    ARM: begin
                        if (tick_edge) begin
                            state      <= MEASURE;
                            cnt        <= WIDTH'(1);
                            edge_count <= edge_count + 16'd1;
                        end
                    end
                    MEASURE: begin
                        // An edge on the TIMEOUT cycle wins over the timeout.
                        if (tick_edge) begin
                            period     <= cnt;
                            in_range   <= in_window;
                            valid      <= 1'b1;
                            timeout    <= 1'b0;
                            cnt        <= WIDTH'(1);
                            edge_count <= edge_count + 16'd1;
                        end else if (cnt == TIMEOUT) begin
                            timeout <= 1'b1;
                            state   <= ARM;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
